// File: rtl/traffic_ctrl_param.sv
// Two-direction traffic-light controller with prescaled tick, all-red clearance,
// safe hold overrides (always through yellow) and a flashing-yellow night mode.
module traffic_ctrl_param #(
    parameter int CLK_DIV  = 25000000,
    parameter int GREEN1_T = 5,
    parameter int GREEN2_T = 5,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 1,
    parameter int CW       = 8
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          hold1,
    input  logic          hold2,
    input  logic          night,
    output logic          r1,
    output logic          g1,
    output logic          y1,
    output logic          r2,
    output logic          g2,
    output logic          y2,
    output logic [CW-1:0] cnt_o,
    output logic [2:0]    phase_o,
    output logic          tick_o
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] G1_LD    = CW'(GREEN1_T);
    localparam logic [CW-1:0] G2_LD    = CW'(GREEN2_T);
    localparam logic [CW-1:0] Y_LD     = CW'(YELLOW_T);
    localparam logic [CW-1:0] AR_LD    = CW'(ALLRED_T);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        S_AR_A  = 3'd0,
        S_G1    = 3'd1,
        S_Y1    = 3'd2,
        S_AR_B  = 3'd3,
        S_G2    = 3'd4,
        S_Y2    = 3'd5,
        S_NIGHT = 3'd6
    } phase_t;

    logic [PW-1:0] presc;
    logic          tick;
    phase_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          flash, flash_nxt;
    logic          h1, h2;
    logic          last;

    // Prescaler: one-cycle tick when the count sits at its final value
    assign tick = (presc == DIV_LAST);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign h1   = hold1 & ~night;
    assign h2   = hold2 & ~hold1 & ~night;
    assign last = (cnt <= ONE);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_AR_A;
            cnt   <= AR_LD;
            flash <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            flash <= flash_nxt;
        end
    end

    // Every exit from a green passes through yellow; night is honoured only at all-red ends
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flash_nxt = flash;
        if (tick) begin
            unique case (state)
                S_AR_A: begin
                    if (!last) begin
                        cnt_nxt = cnt - ONE;
                    end else if (night) begin
                        state_nxt = S_NIGHT;
                        cnt_nxt   = '0;
                        flash_nxt = 1'b0;
                    end else begin
                        state_nxt = S_G1;
                        cnt_nxt   = G1_LD;
                    end
                end
                S_G1: begin
                    if (night || h2) begin
                        state_nxt = S_Y1;
                        cnt_nxt   = Y_LD;
                    end else if (h1) begin
                        cnt_nxt = cnt;
                    end else if (!last) begin
                        cnt_nxt = cnt - ONE;
                    end else begin
                        state_nxt = S_Y1;
                        cnt_nxt   = Y_LD;
                    end
                end
                S_Y1: begin
                    if (!last) begin
                        cnt_nxt = cnt - ONE;
                    end else begin
                        state_nxt = S_AR_B;
                        cnt_nxt   = AR_LD;
                    end
                end
                S_AR_B: begin
                    if (!last) begin
                        cnt_nxt = cnt - ONE;
                    end else if (night) begin
                        state_nxt = S_NIGHT;
                        cnt_nxt   = '0;
                        flash_nxt = 1'b0;
                    end else begin
                        state_nxt = S_G2;
                        cnt_nxt   = G2_LD;
                    end
                end
                S_G2: begin
                    if (night || h1) begin
                        state_nxt = S_Y2;
                        cnt_nxt   = Y_LD;
                    end else if (h2) begin
                        cnt_nxt = cnt;
                    end else if (!last) begin
                        cnt_nxt = cnt - ONE;
                    end else begin
                        state_nxt = S_Y2;
                        cnt_nxt   = Y_LD;
                    end
                end
                S_Y2: begin
                    if (!last) begin
                        cnt_nxt = cnt - ONE;
                    end else begin
                        state_nxt = S_AR_A;
                        cnt_nxt   = AR_LD;
                    end
                end
                S_NIGHT: begin
                    cnt_nxt = '0;
                    if (!night) begin
                        state_nxt = S_AR_A;
                        cnt_nxt   = AR_LD;
                        flash_nxt = 1'b0;
                    end else begin
                        flash_nxt = ~flash;
                    end
                end
                default: begin
                    state_nxt = S_AR_A;
                    cnt_nxt   = AR_LD;
                    flash_nxt = 1'b0;
                end
            endcase
        end
    end

    // Moore lamp decode straight from the state register
    always_comb begin
        r1 = 1'b0;
        g1 = 1'b0;
        y1 = 1'b0;
        r2 = 1'b0;
        g2 = 1'b0;
        y2 = 1'b0;
        unique case (state)
            S_AR_A, S_AR_B: begin
                r1 = 1'b1;
                r2 = 1'b1;
            end
            S_G1: begin
                g1 = 1'b1;
                r2 = 1'b1;
            end
            S_Y1: begin
                y1 = 1'b1;
                r2 = 1'b1;
            end
            S_G2: begin
                r1 = 1'b1;
                g2 = 1'b1;
            end
            S_Y2: begin
                r1 = 1'b1;
                y2 = 1'b1;
            end
            S_NIGHT: begin
                y1 = flash;
                y2 = flash;
            end
            default: begin
                r1 = 1'b1;
                r2 = 1'b1;
            end
        endcase
    end

    assign cnt_o   = cnt;
    assign phase_o = state;
    assign tick_o  = tick;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Scoreboard bench for traffic_ctrl_param: an elapsed-ticks reference model pushes the
// expected outputs for each clock edge, and they are popped and compared after the edge.
module tb_traffic_ctrl_param;

    localparam int CLK_DIV  = 4;
    localparam int GREEN1_T = 5;
    localparam int GREEN2_T = 4;
    localparam int YELLOW_T = 3;
    localparam int ALLRED_T = 1;
    localparam int CW       = 8;

    logic          clk_in = 1'b0;
    logic          rst_n, hold1, hold2, night;
    logic          r1, g1, y1, r2, g2, y2, tick_o;
    logic [CW-1:0] cnt_o;
    logic [2:0]    phase_o;

    always #5 clk_in = ~clk_in;

    traffic_ctrl_param #(
        .CLK_DIV (CLK_DIV),
        .GREEN1_T(GREEN1_T),
        .GREEN2_T(GREEN2_T),
        .YELLOW_T(YELLOW_T),
        .ALLRED_T(ALLRED_T),
        .CW      (CW)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .hold1  (hold1),
        .hold2  (hold2),
        .night  (night),
        .r1     (r1),
        .g1     (g1),
        .y1     (y1),
        .r2     (r2),
        .g2     (g2),
        .y2     (y2),
        .cnt_o  (cnt_o),
        .phase_o(phase_o),
        .tick_o (tick_o)
    );

    typedef struct {
        logic [2:0]    ph;
        logic [CW-1:0] cnt;
        logic [5:0]    lamps;
        logic          tick;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: phase, ticks elapsed in phase, prescaler count, flash bit
    int m_div, m_ph, m_el;
    bit m_fl;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic int dur(input int ph);
        case (ph)
            0, 3:    return ALLRED_T;
            1:       return GREEN1_T;
            4:       return GREEN2_T;
            2, 5:    return YELLOW_T;
            default: return 0;
        endcase
    endfunction

    function automatic int mcnt();
        return (m_ph == 6) ? 0 : dur(m_ph) - m_el;
    endfunction

    // {r1,y1,g1,r2,y2,g2}
    function automatic logic [5:0] lamps_of(input int ph, input bit fl);
        case (ph)
            0, 3:    return 6'b100_100;
            1:       return 6'b001_100;
            2:       return 6'b010_100;
            4:       return 6'b100_001;
            5:       return 6'b100_010;
            6:       return {1'b0, fl, 1'b0, 1'b0, fl, 1'b0};
            default: return 6'b000_000;
        endcase
    endfunction

    task automatic model_reset();
        m_div = 0;
        m_ph  = 0;
        m_el  = 0;
        m_fl  = 0;
    endtask

    task automatic go(input int ph);
        m_ph = ph;
        m_el = 0;
        m_fl = 0;
    endtask

    task automatic model_step();
        bit tk, e1, e2, done;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tk    = (m_div == CLK_DIV - 1);
        m_div = tk ? 0 : m_div + 1;
        if (!tk) return;
        e1   = hold1 && !night;
        e2   = hold2 && !hold1 && !night;
        done = (m_el + 1 >= dur(m_ph));
        case (m_ph)
            0: if (done) go(night ? 6 : 1); else m_el++;
            3: if (done) go(night ? 6 : 4); else m_el++;
            2: if (done) go(3); else m_el++;
            5: if (done) go(0); else m_el++;
            1: begin
                if (night || e2) go(2);
                else if (!e1) begin
                    if (done) go(2); else m_el++;
                end
            end
            4: begin
                if (night || e1) go(5);
                else if (!e2) begin
                    if (done) go(5); else m_el++;
                end
            end
            6: if (!night) go(0); else m_fl = ~m_fl;
            default: go(0);
        endcase
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk_in);
        model_step();
        e.ph    = m_ph[2:0];
        e.cnt   = CW'(mcnt());
        e.lamps = lamps_of(m_ph, m_fl);
        e.tick  = (m_div == CLK_DIV - 1);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk("phase", phase_o, e.ph);
        chk("cnt", cnt_o, e.cnt);
        chk("lamps", {r1, y1, g1, r2, y2, g2}, e.lamps);
        chk("tick", tick_o, e.tick);
    endtask

    task automatic run_until_model(input int ph, input int cnt, input int lim, input string tag);
        int i;
        for (i = 0; i < lim; i++) begin
            if (m_ph == ph && (cnt < 0 || mcnt() == cnt)) break;
            cyc();
        end
        chk(tag, phase_o, ph);
    endtask

    task automatic cycles_to_phase(input int ph, input int lim, output int k);
        k = 0;
        while (phase_o != ph && k < lim) begin
            cyc();
            k++;
        end
    endtask

    task automatic count_run(input int ph, input int lim, output int k);
        k = 0;
        while (phase_o == ph && k < lim) begin
            cyc();
            k++;
        end
    endtask

    initial begin
        int k, seen_g2;
        rst_n = 1'b1;
        hold1 = 1'b0;
        hold2 = 1'b0;
        night = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_phase", phase_o, 0);
        chk("rst_cnt", cnt_o, ALLRED_T);
        chk("rst_lamps", {r1, y1, g1, r2, y2, g2}, 6'b100_100);
        chk("rst_tick", tick_o, 0);
        repeat (2) cyc();
        rst_n = 1'b1;

        // T1: free run, phase lengths in cycles
        cycles_to_phase(1, 20, k);  chk("t1_first_g1", k, 4);
        count_run(1, 40, k);        chk("t1_g1_len", k, 20);
        count_run(2, 40, k);        chk("t1_y1_len", k, 12);
        count_run(3, 40, k);        chk("t1_arb_len", k, 4);
        count_run(4, 40, k);        chk("t1_g2_len", k, 16);
        count_run(5, 40, k);        chk("t1_y2_len", k, 12);
        count_run(0, 40, k);        chk("t1_ara_len", k, 4);

        // T2: hold1 in G1 at cnt 3
        run_until_model(1, 3, 100, "t2_reach");
        hold1 = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (phase_o == 1 && cnt_o == 3 && g1) k++;
        end
        chk("t2_frozen", k, 40);
        hold1 = 1'b0;
        cycles_to_phase(2, 40, k);  chk("t2_y1_after", k, 12);

        // T3: hold1 rising at G2 entry
        run_until_model(4, 4, 100, "t3_reach");
        hold1 = 1'b1;
        cycles_to_phase(5, 20, k);  chk("t3_to_y2", k, 4);
        chk("t3_y2_r1", {y2, r1}, 2'b11);
        cycles_to_phase(1, 40, k);  chk("t3_to_g1", k, 16);
        count_run(1, 60, k);        chk("t3_g1_held", k, 60);

        // T4: both holds from reset
        hold2 = 1'b1;
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        seen_g2 = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (phase_o == 4) seen_g2++;
        end
        chk("t4_no_g2", seen_g2, 0);
        hold1 = 1'b0;
        hold2 = 1'b0;

        // T5: night requested in G1
        run_until_model(1, -1, 100, "t5_reach");
        night = 1'b1;
        cycles_to_phase(6, 60, k);
        chk("t5_night", phase_o, 6);
        repeat (32) cyc();
        chk("t5_rg_off", {r1, g1, r2, g2}, 4'b0000);
        night = 1'b0;
        cycles_to_phase(1, 40, k);
        chk("t5_g1_cnt", cnt_o, GREEN1_T);

        // T6: asynchronous reset mid-Y2
        run_until_model(5, -1, 200, "t6_reach");
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_phase", phase_o, 0);
        chk("t6_cnt", cnt_o, 1);
        chk("t6_lamps", {r1, y1, g1, r2, y2, g2}, 6'b100_100);
        repeat (2) cyc();
        rst_n = 1'b1;
        cycles_to_phase(1, 20, k);  chk("t6_to_g1", k, 4);
        repeat (20) cyc();
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
